// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_scanner
//  Description : Accepts a 14-bit binary value over valid/ready, converts it
//                to four BCD digits with a sequential double-dabble engine,
//                and time-multiplexes the digits onto one BCD bus with
//                active-low digit selects for a 4-digit common-anode display.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] in_value,
    output logic [3:0]  bcd_digit,
    output logic [3:0]  digit_sel_n,
    output logic        overflow
);

    localparam int            C_CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(REFRESH_DIV - 1);
    localparam logic [13:0]   C_MAX_VAL = 14'd9999;
    localparam logic [3:0]    C_LAST_STEP = 4'd13;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [3:0]      r_step;
    logic [29:0]     r_shift;      // {bcd[15:0], bin[13:0]}
    logic            r_pend_ovf;
    logic [15:0]     r_disp;
    logic            r_overflow;
    logic [C_CW-1:0] r_refresh_cnt;
    logic [1:0]      r_scan_idx;

    logic [15:0]     w_bcd_adj;
    logic [29:0]     w_shift_nxt;
    logic [13:0]     w_in_clamped;
    logic            w_in_ovf;
    logic [3:0]      w_blank;
    logic [3:0]      w_digit;

    assign w_in_ovf     = (in_value > C_MAX_VAL);
    assign w_in_clamped = w_in_ovf ? C_MAX_VAL : in_value;
    assign overflow     = r_overflow;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_CONV;
            S_CONV:  if (r_step == C_LAST_STEP) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: ready only while idle
    always_comb begin
        in_ready = (r_state == S_IDLE);
    end

    // Double-dabble step: add 3 to every BCD nibble >= 5, then shift left
    always_comb begin
        w_bcd_adj = r_shift[29:14];
        for (int k = 0; k < 4; k++) begin
            if (w_bcd_adj[k*4 +: 4] >= 4'd5) begin
                w_bcd_adj[k*4 +: 4] = w_bcd_adj[k*4 +: 4] + 4'd3;
            end
        end
        w_shift_nxt = {w_bcd_adj[14:0], r_shift[13:0], 1'b0};
    end

    // Conversion datapath; display register only changes in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step     <= 4'd0;
            r_shift    <= 30'd0;
            r_pend_ovf <= 1'b0;
            r_disp     <= 16'd0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift    <= {16'd0, w_in_clamped};
                        r_pend_ovf <= w_in_ovf;
                        r_step     <= 4'd0;
                    end
                end
                S_CONV: begin
                    r_shift <= w_shift_nxt;
                    r_step  <= r_step + 4'd1;
                end
                S_DONE: begin
                    r_disp     <= r_shift[29:14];
                    r_overflow <= r_pend_ovf;
                end
                default: ;
            endcase
        end
    end

    // Free-running scan timer, independent of the conversion FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= 2'd0;
        end else if (r_refresh_cnt == C_CNT_MAX) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= r_scan_idx + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // Leading-zero blanking and digit/select decode for the scanned slot
    always_comb begin
        w_blank = 4'b0000;
        if (BLANK_LZ != 0) begin
            w_blank[3] = (r_disp[15:12] == 4'd0);
            w_blank[2] = w_blank[3] && (r_disp[11:8] == 4'd0);
            w_blank[1] = w_blank[2] && (r_disp[7:4] == 4'd0);
        end
        w_digit = r_disp[{r_scan_idx, 2'b00} +: 4];
        if (w_blank[r_scan_idx]) begin
            bcd_digit   = 4'd0;
            digit_sel_n = 4'b1111;
        end else begin
            bcd_digit   = w_digit;
            digit_sel_n = ~(4'b0001 << r_scan_idx);
        end
    end

endmodule
`default_nettype wire
